// File: rtl/change_dispenser.sv
// change_dispenser: greedy quarter/dime/nickel payout through a pulse/ack hopper.
// A start in IDLE captures the credit. Each coin that the hopper acknowledges is followed by an
// update strobe that carries the new balance. If the hopper does not acknowledge in time, the
// sticky fault flag is set and the payout ends. Any residue below a nickel stays as credit.
// Optional feature macro: HOPPER_EMPTY_SENSE_EN. It adds the empty[2:0] input ({q,d,n}).
// While the macro is undefined, every tube is treated as never empty.
module change_dispenser #(
  parameter int W            = 8,
  parameter int QUARTER      = 25,
  parameter int DIME         = 10,
  parameter int NICKEL       = 5,
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] amount,
  input  logic         hopper_ack,
`ifdef HOPPER_EMPTY_SENSE_EN
  input  logic [2:0]   empty,
`endif
  output logic         eject_q,
  output logic         eject_d,
  output logic         eject_n,
  output logic         busy,
  output logic         update_total_money,
  output logic [W-1:0] remaining_money,
  output logic         done,
  output logic         fault
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [W-1:0]  Q_VAL      = W'(QUARTER);
  localparam logic [W-1:0]  D_VAL      = W'(DIME);
  localparam logic [W-1:0]  N_VAL      = W'(NICKEL);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_EJECT    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  rem, rem_nxt;
  logic [W-1:0]  coin, coin_nxt;
  logic [2:0]    eject, eject_nxt;       // {q,d,n}, one-hot or zero
  logic [PW-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [TW-1:0] ack_cnt, ack_cnt_nxt;
  logic          busy_nxt, update_nxt, done_nxt, fault_nxt;
  logic [W-1:0]  remaining_nxt;
  logic [2:0]    tube_empty;

`ifdef HOPPER_EMPTY_SENSE_EN
  assign tube_empty = empty;
`else
  assign tube_empty = 3'b000;
`endif

  assign eject_q = eject[2];
  assign eject_d = eject[1];
  assign eject_n = eject[0];

  // State register and every registered output; reset drops the ejects at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      rem                <= {W{1'b0}};
      coin               <= {W{1'b0}};
      eject              <= 3'b000;
      pulse_cnt          <= {PW{1'b0}};
      ack_cnt            <= {TW{1'b0}};
      busy               <= 1'b0;
      update_total_money <= 1'b0;
      remaining_money    <= {W{1'b0}};
      done               <= 1'b0;
      fault              <= 1'b0;
    end else begin
      state              <= state_nxt;
      rem                <= rem_nxt;
      coin               <= coin_nxt;
      eject              <= eject_nxt;
      pulse_cnt          <= pulse_cnt_nxt;
      ack_cnt            <= ack_cnt_nxt;
      busy               <= busy_nxt;
      update_total_money <= update_nxt;
      remaining_money    <= remaining_nxt;
      done               <= done_nxt;
      fault              <= fault_nxt;
    end
  end

  // Next-state and next-output logic for the payout sequence.
  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem;
    coin_nxt      = coin;
    eject_nxt     = 3'b000;
    pulse_cnt_nxt = pulse_cnt;
    ack_cnt_nxt   = ack_cnt;
    busy_nxt      = busy;
    update_nxt    = 1'b0;
    remaining_nxt = remaining_money;
    done_nxt      = 1'b0;
    fault_nxt     = fault;
    case (state)
      S_IDLE: begin
        if (start) begin
          rem_nxt   = amount;
          busy_nxt  = 1'b1;
          fault_nxt = 1'b0;
          state_nxt = S_SELECT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SELECT: begin
        // The largest coin that fits and whose tube is not empty wins.
        pulse_cnt_nxt = {PW{1'b0}};
        if (!tube_empty[2] && (rem >= Q_VAL)) begin
          coin_nxt  = Q_VAL;
          eject_nxt = 3'b100;
          state_nxt = S_EJECT;
        end else if (!tube_empty[1] && (rem >= D_VAL)) begin
          coin_nxt  = D_VAL;
          eject_nxt = 3'b010;
          state_nxt = S_EJECT;
        end else if (!tube_empty[0] && (rem >= N_VAL)) begin
          coin_nxt  = N_VAL;
          eject_nxt = 3'b001;
          state_nxt = S_EJECT;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = S_FINISH;
        end
      end
      S_EJECT: begin
        // Hold the pulse for exactly PULSE_CYCLES cycles; hopper_ack is ignored here.
        if (pulse_cnt == PULSE_LAST) begin
          eject_nxt   = 3'b000;
          ack_cnt_nxt = {TW{1'b0}};
          state_nxt   = S_WAIT_ACK;
        end else begin
          eject_nxt     = eject;
          pulse_cnt_nxt = pulse_cnt + PW'(1);
        end
      end
      S_WAIT_ACK: begin
        if (hopper_ack) begin
          // SELECT only picks a coin that fits, so this subtraction cannot wrap.
          rem_nxt       = rem - coin;
          remaining_nxt = rem - coin;
          update_nxt    = 1'b1;
          state_nxt     = S_SELECT;
        end else if (ack_cnt == ACK_LAST) begin
          fault_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_FINISH;
        end else begin
          ack_cnt_nxt = ack_cnt + TW'(1);
        end
      end
      S_FINISH: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser.
// The reference model computes greedy payouts with plain arithmetic and queues the expected
// ejects, balance updates and done events. A monitor pops that queue and compares each entry
// against what the DUT presents.
module tb_change_dispenser;

  localparam int W = 8;
  localparam int PULSE_CYCLES = 4;
  localparam int ACK_TIMEOUT = 255;

  typedef struct {
    int kind;   // 0 eject (one-hot {q,d,n}), 1 update (balance), 2 done (1000*fault + balance)
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic reset, start, hopper_ack;
  logic [W-1:0] amount;
  logic [2:0] empty;
  logic eject_q, eject_d, eject_n, busy, update_total_money, done, fault;
  logic [W-1:0] remaining_money;
  logic [2:0] ej;

  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit lat_pending = 1'b0;
  int model_remaining = 0;
  bit ack_en = 1'b1;
  bit rand_delay = 1'b0;
  bit spurious = 1'b0;
  int ack_delay = 3;

  change_dispenser #(
    .W(W), .QUARTER(25), .DIME(10), .NICKEL(5),
    .PULSE_CYCLES(PULSE_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .amount(amount),
    .hopper_ack(hopper_ack),
`ifdef HOPPER_EMPTY_SENSE_EN
    .empty(empty),
`endif
    .eject_q(eject_q),
    .eject_d(eject_d),
    .eject_n(eject_n),
    .busy(busy),
    .update_total_money(update_total_money),
    .remaining_money(remaining_money),
    .done(done),
    .fault(fault)
  );

  assign ej = {eject_q, eject_d, eject_n};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Expected events for one payout, computed from the greedy rule.
  task automatic model_payout(input int amt, input bit acks, input logic [2:0] emp);
    int rem;
    int vals[3];
    int pick;
    vals = '{25, 10, 5};
    rem = amt;
    while (1) begin
      pick = -1;
      for (int i = 0; i < 3; i++)
        if (pick < 0 && !emp[2-i] && rem >= vals[i]) pick = i;
      if (pick < 0) break;
      exp_q.push_back('{0, 4 >> pick});
      if (!acks) begin
        exp_q.push_back('{2, 1000 + model_remaining});
        return;
      end
      rem = rem - vals[pick];
      model_remaining = rem;
      exp_q.push_back('{1, rem});
    end
    exp_q.push_back('{2, model_remaining});
  endtask

  task automatic pop_cmp(input int kind, input int val);
    ev_t e;
    string nm;
    case (kind)
      0: nm = "eject";
      1: nm = "update";
      default: nm = "done";
    endcase
    if (exp_q.size() == 0) begin
      chk({"unexpected_", nm}, kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, kind, e.kind);
      chk({nm, "_value"}, val, e.val);
    end
  endtask

  // Monitor: watch eject rises, update strobes and done, and compare them against the scoreboard.
  initial begin : monitor
    logic [2:0] prev;
    int width;
    prev = 3'b000;
    width = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 3'b000;
        width = 0;
      end else begin
        if (ej != 3'b000) chk("eject_onehot", $countones(ej), 1);
        if (ej != 3'b000 && prev == 3'b000) begin
          width = 1;
          if (lat_pending) begin
            chk("start_latency", cyc - start_cyc, 2);
            lat_pending = 1'b0;
          end
          pop_cmp(0, int'(ej));
        end else if (ej != 3'b000) begin
          width++;
        end else if (prev != 3'b000) begin
          chk("pulse_width", width, PULSE_CYCLES);
        end
        if (update_total_money) pop_cmp(1, int'(remaining_money));
        if (done) begin
          if (lat_pending) begin
            chk("done_latency", cyc - start_cyc, 2);
            lat_pending = 1'b0;
          end
          pop_cmp(2, (fault ? 1000 : 0) + int'(remaining_money));
        end
        prev = ej;
      end
    end
  end

  // Hopper model: acknowledge each coin a chosen number of cycles after its pulse ends.
  initial begin : hopper
    logic [2:0] prev;
    bit pend;
    int cnt;
    prev = 3'b000;
    pend = 1'b0;
    cnt = 0;
    hopper_ack = 1'b0;
    forever begin
      @(negedge clk);
      hopper_ack = 1'b0;
      if (reset) begin
        prev = 3'b000;
        pend = 1'b0;
      end else begin
        if (ej != 3'b000 && prev == 3'b000 && spurious) hopper_ack = 1'b1;
        if (ej == 3'b000 && prev != 3'b000 && ack_en) begin
          pend = 1'b1;
          cnt = rand_delay ? int'($urandom_range(0, 6)) : ack_delay;
        end
        if (pend) begin
          if (cnt == 0) begin
            hopper_ack = 1'b1;
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
        prev = ej;
      end
    end
  end

  task automatic run_txn(input int amt, input bit acks, input logic [2:0] emp, input bit inject);
    int n;
    bit got;
    ack_en = acks;
    empty = emp;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    model_payout(amt, acks, emp);
    @(posedge clk);
    #1;
    start = 1'b1;
    amount = W'(amt);
    start_cyc = cyc;
    lat_pending = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    amount = W'($urandom);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (inject && i == 10) begin
        start = 1'b1;
        amount = W'(99);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", int'(got), 1);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : stim
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    amount = '0;
    empty = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_ejects", int'(ej), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_remaining", int'(remaining_money), 0);
    chk("reset_done_fault_update", int'({done, fault, update_total_money}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed payouts: 65, 7, 0, ack timeout on 25, start ignored while busy.
    ack_delay = 3;
    run_txn(65, 1'b1, 3'b000, 1'b0);
    run_txn(7, 1'b1, 3'b000, 1'b0);
    run_txn(0, 1'b1, 3'b000, 1'b0);
    run_txn(25, 1'b0, 3'b000, 1'b0);
    chk("fault_sticky", int'(fault), 1);
    run_txn(65, 1'b1, 3'b000, 1'b1);
    chk("fault_cleared", int'(fault), 0);

    // Reset while a quarter is being ejected.
    model_payout(30, 1'b1, 3'b000);
    @(posedge clk);
    #1;
    start = 1'b1;
    amount = W'(30);
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (eject_q) begin
        seen = 1'b1;
        break;
      end
    end
    chk("eject_before_reset", int'(seen), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_ejects", int'(ej), 0);
    chk("async_reset_busy", int'(busy), 0);
    exp_q.delete();
    lat_pending = 1'b0;
    model_remaining = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_done_after_reset", int'(done), 0);
    run_txn(30, 1'b1, 3'b000, 1'b0);

`ifdef HOPPER_EMPTY_SENSE_EN
    run_txn(50, 1'b1, 3'b100, 1'b0);
    run_txn(40, 1'b1, 3'b111, 1'b0);
`endif

    // Random payouts with random ack delays and stray acks during the pulse.
    rand_delay = 1'b1;
    spurious = 1'b1;
    for (int t = 0; t < 25; t++)
      run_txn(int'($urandom_range(0, 120)), 1'b1, 3'b000, ($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
